// File: rtl/fp_widen_pkg.sv
// rtl/fp_widen_pkg.sv - shared modes, exponent constants and stage-1 record for the FP64 widener
// Purpose: mode encoding, FP64 exponent offsets/subnormal bases, and the
// record passed from the unpack stage to the normalise stage.
package fp_widen_pkg;

  typedef enum logic [1:0] {
    MODE_FP16 = 2'd0,
    MODE_FP32 = 2'd1,
    MODE_PASS = 2'd2,
    MODE_BF16 = 2'd3
  } fp_mode_e;

  localparam int FP64_BIAS     = 1023;
  localparam int FP16_EXP_OFF  = FP64_BIAS - 15;    // 1008
  localparam int FP32_EXP_OFF  = FP64_BIAS - 127;   // 896
  // Exponent of a subnormal whose leading one sits at mantissa bit 0.
  localparam int FP16_SUB_BASE = FP16_EXP_OFF - 9;  // 999
  localparam int FP32_SUB_BASE = FP32_EXP_OFF - 22; // 874

  localparam int FP16_EXP_MAX  = 31;
  localparam int FP32_EXP_MAX  = 255;
  localparam int FP64_EXP_MAX  = 2047;

  // Bit position in the 52-bit fraction where the narrow mantissa's LSB lands.
  localparam int FP16_FRAC_POS = 42;
  localparam int FP32_FRAC_POS = 29;

  // Stage-1 result: everything is final except the subnormal left shift.
  typedef struct packed {
    logic        sign;
    logic        sub;
    logic [10:0] exp;
    logic [51:0] frac;
    logic [5:0]  shamt;
    logic        nan;
  } s1_t;

  function automatic logic [5:0] msb_index(input logic [51:0] v);
    msb_index = '0;
    for (int i = 0; i < 52; i++) begin
      if (v[i]) msb_index = 6'(i);
    end
  endfunction

endpackage

// File: rtl/fp_widen_lane.sv
// rtl/fp_widen_lane.sv - one 64-bit lane of the two-stage FP16/FP32/BF16 to FP64 widener
// Purpose: S1 unpacks, classifies and finds the leading one; S2 normalises
// subnormals and packs the FP64 word. No handshake logic; the parent drives
// the stage enables.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   s1_en, s2_en   stage load enables
//   mode           conversion mode of the beat being loaded into S1
//   din            64-bit lane input (narrow formats in the low bits)
//   dout, nan      FP64 result and its NaN flag (S2 register outputs)
module fp_widen_lane
  import fp_widen_pkg::*;
#(
  parameter bit PIPE_RST_DATA = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s1_en,
  input  logic        s2_en,
  input  logic [1:0]  mode,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        nan
);

  fp_mode_e    mode_e;
  logic [31:0] w32;
  logic        sgn, e_zero, e_max;
  logic [51:0] frac52;
  logic [10:0] exp_norm, sub_base;
  logic [5:0]  frac_pos, msb;
  s1_t         s1_d, s1_q;
  logic [63:0] s2_d;

  assign mode_e = fp_mode_e'(mode);

  always_comb begin
    // BF16 is the upper half of an FP32 word.
    w32 = (mode_e == MODE_BF16) ? {din[15:0], 16'h0000} : din[31:0];
    if (mode_e == MODE_FP16) begin
      sgn      = din[15];
      e_zero   = (din[14:10] == 5'd0);
      e_max    = (din[14:10] == 5'(FP16_EXP_MAX));
      frac52   = {din[9:0], 42'd0};
      exp_norm = {6'd0, din[14:10]} + 11'(FP16_EXP_OFF);
      sub_base = 11'(FP16_SUB_BASE);
      frac_pos = 6'(FP16_FRAC_POS);
    end else begin
      sgn      = w32[31];
      e_zero   = (w32[30:23] == 8'd0);
      e_max    = (w32[30:23] == 8'(FP32_EXP_MAX));
      frac52   = {w32[22:0], 29'd0};
      exp_norm = {3'd0, w32[30:23]} + 11'(FP32_EXP_OFF);
      sub_base = 11'(FP32_SUB_BASE);
      frac_pos = 6'(FP32_FRAC_POS);
    end
    msb = msb_index(frac52);

    s1_d      = '0;
    s1_d.sign = sgn;
    if (mode_e == MODE_PASS) begin
      s1_d.sign = din[63];
      s1_d.exp  = din[62:52];
      s1_d.frac = din[51:0];
      s1_d.nan  = (din[62:52] == 11'(FP64_EXP_MAX)) && (din[51:0] != '0);
    end else if (e_max) begin
      s1_d.exp = 11'(FP64_EXP_MAX);
      if (frac52 != '0) begin
        // Quiet the NaN, keep the payload bits that fit below the quiet bit.
        s1_d.frac = {1'b1, frac52[50:0]};
        s1_d.nan  = 1'b1;
      end
    end else if (e_zero) begin
      if (frac52 != '0) begin
        s1_d.sub   = 1'b1;
        s1_d.exp   = sub_base + {5'd0, msb} - {5'd0, frac_pos};
        s1_d.frac  = frac52;
        // Shifting the leading one out of the top makes it the hidden bit.
        s1_d.shamt = 6'd52 - msb;
      end
    end else begin
      s1_d.exp  = exp_norm;
      s1_d.frac = frac52;
    end
  end

  always_comb begin
    s2_d = {s1_q.sign, s1_q.exp, s1_q.sub ? (s1_q.frac << s1_q.shamt) : s1_q.frac};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if (PIPE_RST_DATA) begin
        s1_q <= '0;
        dout <= '0;
        nan  <= 1'b0;
      end
    end else begin
      if (s1_en) s1_q <= s1_d;
      if (s2_en) begin
        dout <= s2_d;
        nan  <= s1_q.nan;
      end
    end
  end

endmodule

// File: rtl/fp_widen_converter.sv
// rtl/fp_widen_converter.sv - multi-lane pipelined widening converter to FP64 with valid/ready
// Purpose: LANES independent lanes sharing one mode and one handshake;
// two-stage pipeline, latency 2, one beat per cycle, capacity 2 beats.
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   Ctrl_sig                    per-beat mode (0 FP16, 1 FP32, 2 FP64 pass, 3 BF16)
//   input_valid/ready/data      input beat, lane i at [64i+63:64i]
//   output_valid/ready/data     FP64 result beat
//   output_nan                  per-lane NaN flag, qualified by output_valid
module fp_widen_converter
  import fp_widen_pkg::*;
#(
  parameter int LANES         = 2,
  parameter bit PIPE_RST_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            Ctrl_sig,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [64*LANES-1:0]   input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [64*LANES-1:0]   output_data,
  output logic [LANES-1:0]      output_nan
);

  logic             s1_valid, s2_valid;
  logic             s2_ready, s1_en, s2_en;
  logic [LANES-1:0] lane_nan;

  // Ready ripples back combinationally so a full pipe still streams when
  // the consumer accepts.
  assign s2_ready    = !s2_valid || output_ready;
  assign input_ready = !s1_valid || s2_ready;
  assign s1_en       = input_valid && input_ready;
  assign s2_en       = s1_valid && s2_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (input_ready) s1_valid <= input_valid;
      if (s2_ready)    s2_valid <= s1_valid;
    end
  end

  assign output_valid = s2_valid;
  // Gate so the flag drops with reset even when data registers are not cleared.
  assign output_nan   = lane_nan & {LANES{s2_valid}};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_widen_lane #(
      .PIPE_RST_DATA(PIPE_RST_DATA)
    ) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .s1_en(s1_en),
      .s2_en(s2_en),
      .mode (Ctrl_sig),
      .din  (input_data[64*i +: 64]),
      .dout (output_data[64*i +: 64]),
      .nan  (lane_nan[i])
    );
  end

endmodule
